// File: rtl/pc_ctl_multi.sv
// Fetch-stage PC controller: advances by the byte length of up to LANES decoded
// instructions per cycle and handles trap/branch redirects with an epoch tag.
module pc_ctl_lane (
  input  logic       prev_ok,
  input  logic       valid,
  input  logic       compressed,
  output logic       ok,
  output logic [2:0] inc
);
  assign ok  = prev_ok & valid;
  assign inc = ok ? (compressed ? 3'd2 : 3'd4) : 3'd0;
endmodule

module pc_ctl_multi #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int              LANES    = 2,
  parameter int              EPOCH_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               trap_en,
  input  logic [XLEN-1:0]    trap_pc,
  input  logic               bj_en,
  input  logic [XLEN-1:0]    bj_pc,
  input  logic [LANES-1:0]   inst_valid,
  input  logic [LANES-1:0]   inst_compressed,
  output logic [XLEN-1:0]    pc,
  output logic [EPOCH_W-1:0] epoch,
  output logic               redirect,
  output logic               misalign_err,
  output logic [1:0]         state
);
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               redirect_q, redirect_d;
  logic               err_q, err_d;

  // Lane i only counts if every lower lane also counted (contiguous prefix).
  logic [LANES-1:0]      lane_ok;
  logic [LANES-1:0][2:0] lane_inc;

  genvar i;
  generate
    for (i = 0; i < LANES; i++) begin : g_lane
      if (i == 0) begin : g_first
        pc_ctl_lane u_lane (.prev_ok(1'b1), .valid(inst_valid[i]),
                            .compressed(inst_compressed[i]),
                            .ok(lane_ok[i]), .inc(lane_inc[i]));
      end else begin : g_rest
        pc_ctl_lane u_lane (.prev_ok(lane_ok[i-1]), .valid(inst_valid[i]),
                            .compressed(inst_compressed[i]),
                            .ok(lane_ok[i]), .inc(lane_inc[i]));
      end
    end
  endgenerate

  logic [XLEN-1:0] inc_sum;
  logic [XLEN-1:0] tgt;

  always_comb begin
    inc_sum = '0;
    for (int k = 0; k < LANES; k++) inc_sum = inc_sum + XLEN'(lane_inc[k]);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epoch_d    = epoch_q;
    redirect_d = 1'b0;
    err_d      = err_q;
    tgt        = trap_en ? trap_pc : bj_pc;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (trap_en || bj_en) begin
          if (tgt[0]) begin
            state_d = FAULT;
            err_d   = 1'b1;
          end else begin
            pc_d       = tgt;
            epoch_d    = epoch_q + EPOCH_W'(1);
            redirect_d = 1'b1;
          end
        end else if (!stall) begin
          pc_d = pc_q + inc_sum;
        end
      end
      FAULT: begin
        if (trap_en && !trap_pc[0]) begin
          state_d    = RUN;
          pc_d       = trap_pc;
          epoch_d    = epoch_q + EPOCH_W'(1);
          redirect_d = 1'b1;
          err_d      = 1'b0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      epoch_q    <= '0;
      redirect_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      redirect_q <= redirect_d;
      err_q      <= err_d;
    end
  end

  assign pc           = pc_q;
  assign epoch        = epoch_q;
  assign redirect     = redirect_q;
  assign misalign_err = err_q;
  assign state        = state_q;
endmodule

// File: tb/tb_pc_ctl_multi.sv
// Scoreboard bench for pc_ctl_multi: directed vectors push expected state,
// a negedge monitor pops and compares.
module tb_pc_ctl_multi;
  logic        clk = 1'b0;
  logic        rst, stall, trap_en, bj_en;
  logic [63:0] trap_pc, bj_pc;
  logic [1:0]  inst_valid, inst_compressed;
  logic [63:0] pc;
  logic [1:0]  epoch;
  logic        redirect, misalign_err;
  logic [1:0]  state;

  typedef struct packed {
    logic [63:0] pc;
    logic [1:0]  ep;
    logic        r;
    logic        e;
    logic [1:0]  st;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [1:0] BOOT = 2'd0, RUN = 2'd1, FLT = 2'd2;
  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  pc_ctl_multi dut (
    .clk(clk), .rst(rst), .stall(stall), .trap_en(trap_en), .trap_pc(trap_pc),
    .bj_en(bj_en), .bj_pc(bj_pc), .inst_valid(inst_valid),
    .inst_compressed(inst_compressed), .pc(pc), .epoch(epoch),
    .redirect(redirect), .misalign_err(misalign_err), .state(state)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs, let the edge happen, then queue the state it should produce.
  task automatic cyc(input logic r, input logic s, input logic te, input logic [63:0] tp,
                     input logic be, input logic [63:0] bp, input logic [1:0] v,
                     input logic [1:0] c, input logic [63:0] epc, input logic [1:0] eep,
                     input logic er, input logic ee, input logic [1:0] est);
    exp_t x;
    rst = r; stall = s; trap_en = te; trap_pc = tp; bj_en = be; bj_pc = bp;
    inst_valid = v; inst_compressed = c;
    @(posedge clk);
    #1;
    x.pc = epc; x.ep = eep; x.r = er; x.e = ee; x.st = est;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t x, a;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      a.pc = pc; a.ep = epoch; a.r = redirect; a.e = misalign_err; a.st = state;
      checks++;
      if (a !== x) begin
        errors++;
        $display("FAIL check%0d: got pc=%h ep=%0d redir=%0b err=%0b st=%0d, want pc=%h ep=%0d redir=%0b err=%0b st=%0d",
                 checks, a.pc, a.ep, a.r, a.e, a.st, x.pc, x.ep, x.r, x.e, x.st);
      end
    end
  end

  initial begin
    // reset with lanes valid; BOOT cycle then first advance
    cyc(1, 0, 0, 0, 0, 0, 2'b11, 2'b00, RPC, 0, 0, 0, BOOT);
    cyc(1, 0, 0, 0, 0, 0, 2'b11, 2'b00, RPC, 0, 0, 0, BOOT);
    cyc(0, 0, 0, 0, 0, 0, 2'b11, 2'b00, RPC, 0, 0, 0, RUN);
    cyc(0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 64'h8000_0008, 0, 0, 0, RUN);
    // lane mixes
    cyc(0, 0, 0, 0, 0, 0, 2'b11, 2'b01, 64'h8000_000E, 0, 0, 0, RUN);
    cyc(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 64'h8000_000E, 0, 0, 0, RUN);
    cyc(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 64'h8000_0012, 0, 0, 0, RUN);
    cyc(0, 0, 0, 0, 0, 0, 2'b11, 2'b11, 64'h8000_0016, 0, 0, 0, RUN);
    // trap beats bj and stall
    cyc(0, 1, 1, 64'h100, 1, 64'h200, 2'b11, 2'b00, 64'h100, 1, 1, 0, RUN);
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 64'h100, 1, 0, 0, RUN);
    // back-to-back redirects, epoch wraps
    cyc(0, 0, 0, 0, 1, 64'h10, 2'b11, 2'b00, 64'h10, 2, 1, 0, RUN);
    cyc(0, 1, 0, 0, 1, 64'h20, 2'b00, 2'b00, 64'h20, 3, 1, 0, RUN);
    cyc(0, 0, 1, 64'h30, 0, 0, 2'b00, 2'b00, 64'h30, 0, 1, 0, RUN);
    cyc(0, 0, 0, 0, 1, 64'h40, 2'b00, 2'b00, 64'h40, 1, 1, 0, RUN);
    cyc(0, 1, 0, 0, 0, 0, 2'b11, 2'b00, 64'h40, 1, 0, 0, RUN);
    // wrap-around of pc
    cyc(0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 2'b00, 2'b00, 64'hFFFF_FFFF_FFFF_FFFC, 2, 1, 0, RUN);
    cyc(0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 64'h4, 2, 0, 0, RUN);
    // misaligned bj -> FAULT; only aligned trap leaves
    cyc(0, 0, 0, 0, 1, 64'h201, 2'b00, 2'b00, 64'h4, 2, 0, 1, FLT);
    cyc(0, 0, 0, 0, 1, 64'h400, 2'b11, 2'b00, 64'h4, 2, 0, 1, FLT);
    cyc(0, 0, 1, 64'h301, 0, 0, 2'b00, 2'b00, 64'h4, 2, 0, 1, FLT);
    cyc(0, 1, 1, 64'h300, 1, 64'h500, 2'b11, 2'b00, 64'h300, 3, 1, 0, RUN);
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 64'h300, 3, 0, 0, RUN);
    // misaligned trap -> FAULT, then reset with redirects pending
    cyc(0, 0, 1, 64'h101, 0, 0, 2'b00, 2'b00, 64'h300, 3, 0, 1, FLT);
    cyc(1, 0, 1, 64'h100, 1, 64'h200, 2'b11, 2'b00, RPC, 0, 0, 0, BOOT);
    cyc(0, 0, 1, 64'h100, 1, 64'h200, 2'b11, 2'b00, RPC, 0, 0, 0, RUN);
    cyc(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 64'h8000_0002, 0, 0, 0, RUN);
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 64'h8000_0002, 0, 0, 0, RUN);
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      $display("FAIL drain: %0d expected entries never checked", exp_q.size());
      $fatal(1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
